// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the fetch port, data port and RAM-side signals
// of the two-port memory arbiter.
//
//   slave  : the arbiter's view (requests and RAM results in, everything else out)
//   master : the environment's view (requesters plus RAM model)
//
// Fetch port : if_req, if_addr -> if_rdata, if_ack
// Data port  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack
// Status     : err (qualifies an ack whose access timed out)
// RAM side   : mem_addr, mem_din, mem_cs, mem_we, mem_oe -> mem_dout, mem_done
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        err;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_done;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_done,
    output if_rdata, if_ack, d_rdata, d_ack, err,
           mem_addr, mem_din, mem_cs, mem_we, mem_oe
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout, mem_done,
    input  if_rdata, if_ack, d_rdata, d_ack, err,
           mem_addr, mem_din, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a read-only fetch port and a read/write data port
// onto one single-ported RAM. One access is in flight at a time:
// IDLE (grant + latch request) -> ACCESS (drive RAM until mem_done or
// timeout) -> DONE (one-cycle ack to the granted port) -> IDLE.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_arbiter_if.slave (fetch port, data port, err, RAM side)
// Parameter:
//   TIMEOUT : ACCESS cycles without mem_done before the access is aborted
//             with err=1 (rdata left untouched).
// Configuration macro:
//   MEM_ARB_RR_EN : defined -> round-robin between the ports (fetch first
//                   after reset); undefined -> fixed priority, data port wins.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter value in the last ACCESS cycle before the timeout fires.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        grant_d;     // 1 = current access belongs to the data port
  logic        pick_d;      // port chosen this cycle if IDLE grants
`ifdef MEM_ARB_RR_EN
  logic        last_d;      // last granted port was the data port
`endif

  logic [31:0] if_rdata_r, d_rdata_r, mem_addr_r, mem_din_r;
  logic        if_ack_r, d_ack_r, err_r, mem_cs_r, mem_we_r, mem_oe_r;

  // NOTE: combinational blocks assign every output unconditionally so no
  // latch can be inferred.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_d = (bus.if_req && bus.d_req) ? !last_d : bus.d_req;
`else
    pick_d = bus.d_req;
`endif
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      grant_d    <= 1'b0;
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
      err_r      <= 1'b0;
      mem_cs_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_oe_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_din_r  <= '0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
`ifdef MEM_ARB_RR_EN
      last_d     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            grant_d  <= pick_d;
`ifdef MEM_ARB_RR_EN
            last_d   <= pick_d;
`endif
            cnt      <= '0;
            mem_cs_r <= 1'b1;
            if (pick_d) begin
              mem_addr_r <= bus.d_addr;
              mem_din_r  <= bus.d_wdata;
              mem_we_r   <= bus.d_we;
              mem_oe_r   <= !bus.d_we;
            end else begin
              mem_addr_r <= bus.if_addr;
              mem_din_r  <= '0;
              mem_we_r   <= 1'b0;
              mem_oe_r   <= 1'b1;
            end
            state <= ACCESS;
          end
        end

        ACCESS: begin
          // mem_done is checked first so a completion in the timeout cycle
          // is still a normal completion.
          if (bus.mem_done || (cnt == CNT_LAST)) begin
            if (bus.mem_done && !mem_we_r) begin
              if (grant_d) d_rdata_r  <= bus.mem_dout;
              else         if_rdata_r <= bus.mem_dout;
            end
            err_r    <= !bus.mem_done;
            if_ack_r <= !grant_d;
            d_ack_r  <= grant_d;
            mem_cs_r <= 1'b0;
            mem_we_r <= 1'b0;
            mem_oe_r <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DONE: begin
          if_ack_r <= 1'b0;
          d_ack_r  <= 1'b0;
          err_r    <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata = if_rdata_r;
  assign bus.if_ack   = if_ack_r;
  assign bus.d_rdata  = d_rdata_r;
  assign bus.d_ack    = d_ack_r;
  assign bus.err      = err_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_din  = mem_din_r;
  assign bus.mem_cs   = mem_cs_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_oe   = mem_oe_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter. The bench plays both
// requesters and the RAM. A transaction-level model tracks pending requests,
// decides the winner from the arbitration rule, and predicts access length,
// err and the rdata registers from the RAM latency it chose.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Requester model
  bit          f_pend, d_pend, d_we_m;
  logic [31:0] f_addr, d_addr_m, d_wdata_m;
  logic [31:0] exp_if_rdata, exp_d_rdata;
`ifdef MEM_ARB_RR_EN
  bit          last_was_d;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit predict_d();
    if (f_pend && d_pend) begin
`ifdef MEM_ARB_RR_EN
      return !last_was_d;
`else
      return 1'b1;
`endif
    end
    return d_pend;
  endfunction

  task automatic apply_reqs();
    bus.if_req  = f_pend;
    bus.if_addr = f_pend ? f_addr : $urandom;
    bus.d_req   = d_pend;
    bus.d_we    = d_pend ? d_we_m : 1'($urandom_range(0, 1));
    bus.d_addr  = d_pend ? d_addr_m : $urandom;
    bus.d_wdata = d_pend ? d_wdata_m : $urandom;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_cs",   32'(bus.mem_cs), 32'd0);
    check("rst_mem_we",   32'(bus.mem_we), 32'd0);
    check("rst_mem_oe",   32'(bus.mem_oe), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_din",  bus.mem_din, 32'd0);
    check("rst_acks_err", 32'({bus.if_ack, bus.d_ack, bus.err}), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata",  bus.d_rdata, 32'd0);
  endtask

  // One arbitrated access. Called at a falling edge while the DUT is idle;
  // RAM asserts mem_done in ACCESS cycle k (k > TO means never in time).
  task automatic do_round(input int k, input logic [31:0] rd_val, output bit won_d);
    bit          wd, got_cs, stable, exp_to, exp_we;
    int          len, exp_len;
    logic [31:0] exp_addr;
    wd       = predict_d();
    won_d    = wd;
    exp_to   = (k > TO);
    exp_len  = exp_to ? TO : k;
    exp_we   = wd ? d_we_m : 1'b0;
    exp_addr = wd ? d_addr_m : f_addr;

    apply_reqs();
    bus.mem_done = 1'($urandom_range(0, 1));   // stray, sampled in IDLE
    got_cs = 1'b0;
    for (int i = 0; i < 4 && !got_cs; i++) begin
      @(negedge clk);
      if (bus.mem_cs) got_cs = 1'b1;
    end
    check("access_start", 32'(got_cs), 32'd1);
    check("mem_addr", bus.mem_addr, exp_addr);
    check("mem_we", 32'(bus.mem_we), 32'(exp_we));
    check("mem_oe", 32'(bus.mem_oe), 32'(!exp_we));
    if (exp_we) check("mem_din", bus.mem_din, d_wdata_m);

    len = 0;
    stable = 1'b1;
    for (int i = 0; i < TO + 6; i++) begin
      if (!bus.mem_cs) break;
      len++;
      if (bus.mem_addr !== exp_addr || bus.mem_we !== exp_we ||
          bus.mem_oe !== !exp_we || bus.if_ack || bus.d_ack) stable = 1'b0;
      // Winner's request fields wander during ACCESS; they must be ignored.
      if (wd) begin
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_we    = 1'($urandom_range(0, 1));
      end else begin
        bus.if_addr = $urandom;
      end
      bus.mem_done = (len == k);
      bus.mem_dout = (len == k) ? rd_val : $urandom;
      @(negedge clk);
    end
    // Now in DONE: stray mem_done must be ignored.
    bus.mem_done = 1'($urandom_range(0, 1));
    bus.mem_dout = $urandom;

    check("access_len", 32'(len), 32'(exp_len));
    check("ram_ctl_stable", 32'(stable), 32'd1);
    check("if_ack", 32'(bus.if_ack), 32'(!wd));
    check("d_ack", 32'(bus.d_ack), 32'(wd));
    check("err", 32'(bus.err), 32'(exp_to));
    if (!exp_to && !exp_we) begin
      if (wd) exp_d_rdata  = rd_val;
      else    exp_if_rdata = rd_val;
    end
    check("if_rdata", bus.if_rdata, exp_if_rdata);
    check("d_rdata", bus.d_rdata, exp_d_rdata);

`ifdef MEM_ARB_RR_EN
    last_was_d = wd;
`endif
    if (wd) d_pend = 1'b0;
    else    f_pend = 1'b0;
    apply_reqs();

    @(negedge clk);   // IDLE
    bus.mem_done = 1'b0;
    check("ack_pulse_end", 32'({bus.if_ack, bus.d_ack, bus.err, bus.mem_cs}), 32'd0);
  endtask

  task automatic model_reset();
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    f_pend = 1'b0;
    d_pend = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_was_d = 1'b1;
`endif
  endtask

  initial begin
    bit          wd;
    bit          saw_ack;
    logic [31:0] seq;
    logic [31:0] exp_seq;

    model_reset();
    apply_reqs();
    bus.mem_done = 1'b0;
    bus.mem_dout = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Both ports held for four accesses.
    seq = '0;
    f_pend = 1'b1; f_addr = 32'h100;
    for (int r = 0; r < 4; r++) begin
      d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h200; d_wdata_m = 32'h0;
      f_pend = 1'b1;
      do_round(2, $urandom, wd);
      seq[r] = wd;
    end
`ifdef MEM_ARB_RR_EN
    exp_seq = 32'b1010;
`else
    exp_seq = 32'b1111;
`endif
    check("both_req_order", seq, exp_seq);
    if (f_pend || d_pend) do_round(1, $urandom, wd);   // drain held requester

    // Fetch read, done in the 2nd ACCESS cycle.
    f_pend = 1'b1; f_addr = 32'h10;
    do_round(2, 32'hE3A01005, wd);
    check("fetch_rdata", bus.if_rdata, 32'hE3A01005);

    // Data write.
    d_pend = 1'b1; d_we_m = 1'b1; d_addr_m = 32'h20; d_wdata_m = 32'hCAFEF00D;
    do_round(3, $urandom, wd);

    // Data read that never completes: timeout, rdata untouched.
    d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h30; d_wdata_m = $urandom;
    do_round(TO + 5, 32'h12345678, wd);

    // mem_done in the timeout cycle: normal completion.
    d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h34;
    do_round(TO, 32'h0BADBEEF, wd);

    // Reset in the middle of an access.
    d_pend = 1'b1; d_we_m = 1'b0; d_addr_m = 32'h40;
    apply_reqs();
    repeat (3) @(negedge clk);
    check("pre_rst_in_access", 32'(bus.mem_cs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_reset();
    apply_reqs();
    saw_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) saw_ack = 1'b1;
    end
    bus.mem_done = 1'b0;
    check("no_ack_after_rst", 32'(saw_ack), 32'd0);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      if (!f_pend && $urandom_range(0, 1)) begin
        f_pend = 1'b1; f_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 1)) begin
        d_pend = 1'b1; d_we_m = 1'($urandom_range(0, 1));
        d_addr_m = $urandom; d_wdata_m = $urandom;
      end
      if (!f_pend && !d_pend) begin
        f_pend = 1'b1; f_addr = $urandom;
      end
      do_round($urandom_range(1, TO + 2), $urandom, wd);
    end
    while (f_pend || d_pend) do_round($urandom_range(1, TO), $urandom, wd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
